// File: rtl/pgm_loader_pkg.sv
// pgm_loader_pkg: shared state encoding and frame sizes for the program loader
package pgm_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA_HI, S_DATA_LO, S_STB_HI, S_STB_LO, S_CHK, S_DONE
  } state_t;
  localparam int HDR_BYTES = 4;
  localparam int CHK_BYTES = 2;
endpackage

// File: rtl/pgm_loader_if.sv
// pgm_loader_if: byte stream in, RAM program port and status out
interface pgm_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        pgm;
  logic [15:0] pgm_addr;
  logic [15:0] pgm_data;
  logic        pg_wr;
  logic        busy;
  logic        done;
  logic        err;
  modport master (
    input  start, in_data, in_valid,
    output in_ready, pgm, pgm_addr, pgm_data, pg_wr, busy, done, err
  );
  modport slave (
    output start, in_data, in_valid,
    input  in_ready, pgm, pgm_addr, pgm_data, pg_wr, busy, done, err
  );
endinterface

// File: rtl/pgm_strobe_gen.sv
// pgm_strobe_gen: times one word strobe, pg_wr high WR_HI cycles then low WR_LO cycles
module pgm_strobe_gen #(
  parameter int WR_HI = 2,
  parameter int WR_LO = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic en,
  output logic pg_wr,
  output logic hi_done,
  output logic strobe_done
);
  localparam int CW = $clog2(WR_HI + WR_LO + 1);
  logic [CW-1:0] cnt;
  logic          active;
  assign hi_done     = active && cnt == CW'(WR_HI);
  assign strobe_done = active && cnt == CW'(WR_HI + WR_LO);
  // cnt holds the index of the current strobe cycle; a suppressed word keeps pg_wr low but keeps timing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      pg_wr  <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      cnt    <= CW'(1);
      pg_wr  <= en;
    end else if (active) begin
      active <= !strobe_done;
      cnt    <= cnt + 1'b1;
      pg_wr  <= pg_wr && cnt < CW'(WR_HI);
    end
endmodule

// File: rtl/pgm_loader.sv
// pgm_loader: parses a load frame from a byte stream and writes words into RAM (checksum option: PGM_LOADER_CHECKSUM_EN)
module pgm_loader
  import pgm_loader_pkg::*;
#(
  parameter int MEM_SIZE = 512,
  parameter int WR_HI    = 2,
  parameter int WR_LO    = 2
) (
  input logic         clk,
  input logic         rst,
  pgm_loader_if.master bus
);
`ifdef PGM_LOADER_CHECKSUM_EN
  localparam state_t END_S = S_CHK;
  logic [15:0] csum, csum_nx;
  logic        chk_idx, pos_hi;
`else
  localparam state_t END_S = S_DONE;
`endif
  state_t      state;
  logic [15:0] cnt, addr, data;
  logic [7:0]  hi_byte;
  logic [1:0]  hdr_idx;
  logic        own, done_q, err_q, idle, take, go, en, hi_done, strobe_done, to_end, finish;
  assign idle         = state == S_IDLE || state == S_DONE;
  assign bus.in_ready = !(state == S_STB_HI || state == S_STB_LO);
  assign take         = bus.in_valid && bus.in_ready;
  assign go           = take && state == S_DATA_LO;
  assign en           = 32'(addr) < MEM_SIZE;
  assign to_end       = (state == S_HDR && take && hdr_idx == 2'(HDR_BYTES - 1) && cnt == 16'd0) ||
                        (state == S_STB_LO && strobe_done && cnt == 16'd1);
  assign bus.pgm      = own;
  assign bus.busy     = own;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.pgm_addr = addr;
  assign bus.pgm_data = data;
`ifdef PGM_LOADER_CHECKSUM_EN
  assign pos_hi  = state == S_DATA_HI || (state == S_HDR && !hdr_idx[0]) || (state == S_CHK && !chk_idx);
  assign csum_nx = csum ^ (pos_hi ? {bus.in_data, 8'h00} : {8'h00, bus.in_data});
  assign finish  = state == S_CHK && take && chk_idx == 1'(CHK_BYTES - 1);
  // Running XOR of header, data and checksum words; a good frame leaves it at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      csum    <= '0;
      chk_idx <= 1'b0;
    end else if (idle) begin
      csum    <= '0;
      chk_idx <= 1'b0;
    end else if (take) begin
      csum    <= csum_nx;
      chk_idx <= state == S_CHK ? !chk_idx : chk_idx;
    end
`else
  assign finish = to_end;
`endif
  pgm_strobe_gen #(.WR_HI(WR_HI), .WR_LO(WR_LO)) u_stb (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .en         (en),
    .pg_wr      (bus.pg_wr),
    .hi_done    (hi_done),
    .strobe_done(strobe_done)
  );
  // Byte FSM: header capture, word assembly, address/count tracking and sticky status
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr    <= '0;
      data    <= '0;
      hi_byte <= '0;
      hdr_idx <= '0;
      own     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (idle && bus.start) begin
        state   <= S_HDR;
        own     <= 1'b1;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        hdr_idx <= '0;
      end else
        case (state)
          S_HDR: if (take) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0:    cnt[15:8]  <= bus.in_data;
              2'd1:    cnt[7:0]   <= bus.in_data;
              2'd2:    addr[15:8] <= bus.in_data;
              default: addr[7:0]  <= bus.in_data;
            endcase
            if (hdr_idx == 2'(HDR_BYTES - 1)) state <= cnt == 16'd0 ? END_S : S_DATA_HI;
          end
          S_DATA_HI: if (take) begin
            hi_byte <= bus.in_data;
            state   <= S_DATA_LO;
          end
          S_DATA_LO: if (take) begin
            data  <= {hi_byte, bus.in_data};
            err_q <= err_q | !en;
            state <= S_STB_HI;
          end
          S_STB_HI: if (hi_done) state <= S_STB_LO;
          S_STB_LO: if (strobe_done) begin
            addr  <= addr + 16'd1;
            cnt   <= cnt - 16'd1;
            state <= cnt == 16'd1 ? END_S : S_DATA_HI;
          end
`ifdef PGM_LOADER_CHECKSUM_EN
          S_CHK: if (finish) begin
            err_q <= err_q | (csum_nx != 16'd0);
            state <= S_DONE;
          end
`endif
          default: ;
        endcase
      if (finish) begin
        own    <= 1'b0;
        done_q <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pgm_loader.sv
// tb_pgm_loader: directed loads with a write scoreboard and strobe-window monitor
module tb_pgm_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pgm_loader_if bus ();
  pgm_loader dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  int rises = 0;
  int wait_cycles = 0;
  logic [31:0] exp_q[$];
  logic [15:0] words[$];
  logic [15:0] mem[512];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  logic        prev_wr = 1'b0;
  logic        in_lo = 1'b0;
  int          hi_len = 0;
  int          lo_len = 0;
  logic [15:0] a_l, d_l;
  always @(negedge clk) begin
    if (bus.pg_wr && !prev_wr) begin
      rises++;
      a_l = bus.pgm_addr;
      d_l = bus.pgm_data;
      hi_len = 0;
      if (exp_q.size() == 0) check("unexpected_wr", {a_l, d_l}, 32'hDEAD_BEEF);
      else check("wr_addr_data", {a_l, d_l}, exp_q.pop_front());
      if (32'(a_l) < 512) mem[a_l[8:0]] = d_l;
    end
    if (bus.pg_wr) begin
      hi_len++;
      check("ready_in_hi", 32'(bus.in_ready), 0);
      check("addr_stable", 32'(bus.pgm_addr), 32'(a_l));
      check("data_stable", 32'(bus.pgm_data), 32'(d_l));
    end
    if (!bus.pg_wr && prev_wr) begin
      check("hi_len", hi_len, 2);
      in_lo = 1'b1;
      lo_len = 0;
    end
    if (in_lo) begin
      if (bus.in_ready || !bus.busy) begin
        check("lo_len", lo_len, 2);
        in_lo = 1'b0;
      end else lo_len++;
    end
    prev_wr = bus.pg_wr;
  end
  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) check("ready_timeout", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("start_status", {bus.pgm, bus.busy, bus.done, bus.err}, 32'b1100);
  endtask
  task automatic load(input logic [15:0] adr, input int gmax, input bit bad);
    logic [15:0] cs, n, a;
    logic e = 1'b0;
    n = 16'(words.size());
    cs = n ^ adr;
    do_start();
    send(n[15:8], $urandom_range(gmax, 0));
    send(n[7:0], $urandom_range(gmax, 0));
    send(adr[15:8], $urandom_range(gmax, 0));
    send(adr[7:0], $urandom_range(gmax, 0));
    foreach (words[i]) begin
      a = adr + 16'(i);
      if (32'(a) < 512) exp_q.push_back({a, words[i]});
      else e = 1'b1;
      cs ^= words[i];
      send(words[i][15:8], $urandom_range(gmax, 0));
      send(words[i][7:0], $urandom_range(gmax, 0));
    end
    cs ^= bad ? 16'h00FF : 16'h0000;
`ifdef PGM_LOADER_CHECKSUM_EN
    e |= bad;
    send(cs[15:8], $urandom_range(gmax, 0));
    send(cs[7:0], $urandom_range(gmax, 0));
`endif
    wait_cycles = 0;
    while (!bus.done && wait_cycles < 200) begin
      @(posedge clk);
      #1;
      wait_cycles++;
    end
    check("end_status", {bus.done, bus.err, bus.pgm, bus.busy}, {28'd0, 1'b1, e, 2'b00});
    check("queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    int r;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    #12;
    check("reset_flags", {bus.in_ready, bus.pgm, bus.busy, bus.done, bus.err, bus.pg_wr}, 32'b100000);
    check("reset_bus", {bus.pgm_addr, bus.pgm_data}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    words = '{16'h1234, 16'hABCD};
    load(16'h0010, 0, 1'b0);
    check("t1_mem10", 32'(mem[9'h010]), 32'h1234);
    check("t1_mem11", 32'(mem[9'h011]), 32'hABCD);
    r = rises;
    words = '{};
    load(16'h0005, 0, 1'b0);
    check("t2_latency", 32'(wait_cycles <= 1), 1);
    check("t2_no_strobe", rises - r, 0);
    send(8'h55, 0);
    check("done_discard", {bus.done, bus.in_ready, bus.busy}, 32'b110);
    words = '{16'h1111, 16'h2222};
    load(16'h01FF, 0, 1'b0);
    check("t3_mem1ff", 32'(mem[9'h1FF]), 32'h1111);
    words = '{16'hC0DE, 16'h0F0F, 16'h8001, 16'h7E57};
    load(16'h0040, 7, 1'b0);
    foreach (words[i]) check("t4_mem", 32'(mem[9'h040 + 9'(i)]), 32'(words[i]));
    words = '{16'hAAAA, 16'h5555};
    load(16'hFFFF, 3, 1'b0);
    check("wrap_mem0", 32'(mem[9'h000]), 32'h5555);
    do_start();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h30, 0);
    send(8'h77, 0);
    rst = 1'b1;
    #1;
    check("t5_rst_drop", {bus.pgm, bus.pg_wr, bus.busy, bus.in_ready}, 32'b0001);
    @(posedge clk);
    #1;
    rst = 1'b0;
    words = '{16'h5A5A};
    load(16'h0030, 2, 1'b0);
    check("t5_mem30", 32'(mem[9'h030]), 32'h5A5A);
`ifdef PGM_LOADER_CHECKSUM_EN
    words = '{16'hBEEF};
    load(16'h0020, 0, 1'b0);
    check("t6_good_err", 32'(bus.err), 0);
    load(16'h0020, 1, 1'b1);
    check("t6_bad_err", 32'(bus.err), 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
